// File: rtl/sbox_share_sched_pkg.sv
// Shared types, constants and GF(2^8) helpers for the time-shared S-box scheduler.
// The helpers also back the reference sbox_inv_lut that the scheduler drives.
package sbox_share_sched_pkg;

    localparam int   LANE_W   = 8;
    localparam logic SBOX_FWD = 1'b1;
    localparam logic SBOX_INV = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // AES field multiply, reduction polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero without special casing.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'hFE;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) begin
                r = gf_mul(r, p);
            end
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

endpackage

// File: rtl/sbox_inv_lut.sv
// Combinational mixed forward/inverse AES S-box shared by several requesters.
module sbox_inv_lut
    import sbox_share_sched_pkg::*;
(
    input  logic       encrypt,
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);

    always_comb begin
        byte_out = 8'h00;
        unique case (encrypt)
            SBOX_FWD: byte_out = affine_fwd(gf_inv(byte_in));
            SBOX_INV: byte_out = gf_inv(affine_inv(byte_in));
            default:  byte_out = 8'h00;
        endcase
    end

endmodule

// File: rtl/sbox_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                grant[IDX_W'(idx)] = 1'b1;
                grant_idx          = IDX_W'(idx);
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sbox_share_sched.sv
// Round-robin scheduler that streams request words byte-by-byte through one
// external S-box and returns the assembled result to the owning requester.
module sbox_share_sched
    import sbox_share_sched_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int WORD_BYTES = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_encrypt,
    input  logic [NUM_REQ*WORD_BYTES*8-1:0] req_word,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [WORD_BYTES*8-1:0]        resp_word,
    output logic                           sbox_encrypt,
    output logic [7:0]                     sbox_byte_in,
    input  logic [7:0]                     sbox_byte_out,
    output logic                           busy
);

    localparam int WORD_W = WORD_BYTES * LANE_W;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               dir_q, dir_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [WORD_W-1:0]  result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        dir_d        = dir_q;
        word_d       = word_q;
        result_d     = result_q;
        cnt_d        = cnt_q;
        req_ready    = '0;
        resp_valid   = '0;
        sbox_encrypt = SBOX_FWD;
        sbox_byte_in = '0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = grant;
                if (|grant) begin
                    owner_d  = grant_idx;
                    dir_d    = req_encrypt[grant_idx];
                    word_d   = req_word[grant_idx*WORD_W +: WORD_W];
                    cnt_d    = '0;
                    rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d  = ST_SUB;
                end
            end
            ST_SUB: begin
                sbox_encrypt                     = dir_q;
                sbox_byte_in                     = word_q[cnt_q*LANE_W +: LANE_W];
                result_d[cnt_q*LANE_W +: LANE_W] = sbox_byte_out;
                cnt_d                            = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WORD_BYTES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Only the owner's resp_ready can retire the response.
                resp_valid[owner_q] = 1'b1;
                if (resp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            dir_q    <= SBOX_FWD;
            cnt_q    <= '0;
            // NOTE: the datapath words are cleared as well so resp_word and the
            // S-box inputs come out of reset at a known zero, not stale data.
            word_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            result_q <= result_d;
        end
    end

    assign resp_word = (state_q == ST_DONE) ? result_q : '0;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sbox_share_sched.sv
// Randomised scoreboard bench for sbox_share_sched driving a real sbox_inv_lut.
module tb_sbox_share_sched;

    localparam int NR = 2;
    localparam int WB = 4;
    localparam int W  = WB * 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NR-1:0]   req_valid, req_ready, req_encrypt, resp_valid, resp_ready;
    logic [NR*W-1:0] req_word;
    logic [W-1:0]    resp_word;
    logic            sbox_encrypt, busy;
    logic [7:0]      sbox_byte_in, sbox_byte_out;

    always #5 clk = ~clk;

    sbox_share_sched #(.NUM_REQ(NR), .WORD_BYTES(WB)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_encrypt   (req_encrypt),
        .req_word      (req_word),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_word     (resp_word),
        .sbox_encrypt  (sbox_encrypt),
        .sbox_byte_in  (sbox_byte_in),
        .sbox_byte_out (sbox_byte_out),
        .busy          (busy)
    );

    sbox_inv_lut u_sbox (
        .encrypt  (sbox_encrypt),
        .byte_in  (sbox_byte_in),
        .byte_out (sbox_byte_out)
    );

    typedef struct {
        int         owner;
        logic       dir;
        logic [W-1:0] word;
        logic [W-1:0] res;
        int         hs_cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    bit         rst_seen = 1'b0;
    bit         mon_en = 1'b0;
    bit         rand_mode = 1'b0;
    bit         auto_req[NR];
    int         acc_cnt[NR];
    int         acc_seen[NR];
    int         model_rr = 0;
    logic [W-1:0] pend_res[NR];
    logic [7:0] fwd_tbl[256];
    logic [7:0] inv_tbl[256];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Forward table by brute-force inverse search plus the bitwise affine rule;
    // the inverse table is simply the forward table read backwards.
    task automatic build_tables();
        logic [7:0] inv, s, c, xv;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            xv  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (ref_mul(xv, 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int b = 0; b < 8; b++) begin
                s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8]
                     ^ inv[(b + 7) % 8] ^ c[b];
            end
            fwd_tbl[x] = s;
            inv_tbl[s] = xv;
        end
    endtask

    function automatic logic [W-1:0] ref_sub(input logic [W-1:0] word, input logic dir);
        logic [W-1:0] r;
        for (int b = 0; b < WB; b++) begin
            r[b*8 +: 8] = dir ? fwd_tbl[word[b*8 +: 8]] : inv_tbl[word[b*8 +: 8]];
        end
        return r;
    endfunction

    function automatic logic [NR-1:0] model_grant(input logic [NR-1:0] v, input int rr);
        logic [NR-1:0] g;
        g = '0;
        for (int k = NR - 1; k >= 0; k--) begin
            if (v[(rr + k) % NR]) begin
                g = '0;
                g[(rr + k) % NR] = 1'b1;
            end
        end
        return g;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !reset_n;
    end

    // Monitor: tracks the single job in flight from the spec's timing rules.
    always @(negedge clk) begin
        logic [NR-1:0] g, oh;
        exp_t          e;
        int            k, o;
        if (mon_en) begin
            if (rst_seen) begin
                exp_q.delete();
                model_rr = 0;
                check("rst_resp_word", resp_word, 0);
            end
            if (exp_q.size() == 0) begin
                g = model_grant(req_valid, model_rr);
                check("idle_req_ready", req_ready, g);
                check("idle_busy", busy, 0);
                check("idle_resp_valid", resp_valid, 0);
                check("idle_sbox_in", {sbox_encrypt, sbox_byte_in}, {1'b1, 8'h00});
                if (reset_n && g != 0) begin
                    o = 0;
                    for (int i = 0; i < NR; i++) if (g[i]) o = i;
                    e.owner  = o;
                    e.dir    = req_encrypt[o];
                    e.word   = req_word[o*W +: W];
                    e.res    = pend_res[o];
                    e.hs_cyc = cyc;
                    exp_q.push_back(e);
                    model_rr = (o + 1) % NR;
                    acc_cnt[o]++;
                end
            end else begin
                e = exp_q[0];
                k = cyc - e.hs_cyc;
                check("busy_req_ready", req_ready, 0);
                check("busy_flag", busy, 1);
                if (k <= WB) begin
                    check("sub_resp_valid", resp_valid, 0);
                    check("sub_sbox_in", {sbox_encrypt, sbox_byte_in},
                          {e.dir, e.word[(k-1)*8 +: 8]});
                end else begin
                    oh = '0;
                    oh[e.owner] = 1'b1;
                    check("done_resp_valid", resp_valid, oh);
                    check("done_resp_word", resp_word, e.res);
                    check("done_sbox_in", {sbox_encrypt, sbox_byte_in}, {1'b1, 8'h00});
                    if (reset_n && resp_ready[e.owner]) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input int i, input logic [W-1:0] word, input logic dir,
                         input logic [W-1:0] res);
        req_word[i*W +: W] = word;
        req_encrypt[i]     = dir;
        req_valid[i]       = 1'b1;
        pend_res[i]        = res;
    endtask

    task automatic issue_rand(input int i);
        logic [W-1:0] w;
        logic         d;
        w = $urandom;
        d = 1'($urandom_range(0, 1));
        issue(i, w, d, ref_sub(w, d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc_seen[i] != acc_cnt[i]) begin
                acc_seen[i]  = acc_cnt[i];
                req_valid[i] = 1'b0;
            end
            if (rand_mode) begin
                if (req_valid[i] && $urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 2) == 0) issue_rand(i);
                resp_ready[i] = ($urandom_range(0, 3) != 0);
            end else if (auto_req[i] && !req_valid[i]) begin
                issue_rand(i);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || req_valid != 0) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) check("drain_timeout", 0, 1);
        tick();
    endtask

    initial begin
        int n;
        build_tables();
        for (int i = 0; i < NR; i++) begin
            auto_req[i] = 1'b0;
            acc_cnt[i]  = 0;
            acc_seen[i] = 0;
            pend_res[i] = '0;
        end
        reset_n     = 1'b0;
        req_valid   = '0;
        req_encrypt = '0;
        req_word    = '0;
        resp_ready  = '1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (10) tick();

        issue(0, 32'hFF530100, 1'b1, 32'h16ED7C63);
        drain();
        issue(1, 32'h16ED7C63, 1'b0, 32'hFF530100);
        drain();
        issue(0, 32'h00000000, 1'b0, 32'h52525252);
        drain();

        for (int i = 0; i < NR; i++) auto_req[i] = 1'b1;
        repeat (40) tick();
        for (int i = 0; i < NR; i++) auto_req[i] = 1'b0;
        drain();

        // Backpressure on requester 0 while requester 1 waits.
        resp_ready[0] = 1'b0;
        issue_rand(0);
        tick();
        issue_rand(1);
        repeat (25) tick();
        resp_ready[0] = 1'b1;
        drain();

        // Abort a job mid-SUB; afterwards the pointer must be back at 0.
        issue_rand(0);
        n = 0;
        while (req_valid[0] && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("abort_accept_timeout", 0, 1);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        issue_rand(0);
        issue_rand(1);
        drain();

        rand_mode = 1'b1;
        repeat (400) tick();
        rand_mode  = 1'b0;
        resp_ready = '1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
- Time-multiplexes one shared sbox_inv_lut instance (combinational, mixed forward/inverse S-box) among NUM_REQ requesters, e.g. the round datapath and the key expansion.
- Each request is one word of WORD_BYTES bytes plus a direction flag. The block arbitrates round-robin, streams the bytes through the S-box one per cycle, assembles the result and returns it over a valid/ready handshake.
- The S-box sits outside this block; this block drives its inputs and samples its output.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WORD_BYTES, 4, bytes per request word (4 = SubWord, 16 = full state).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- req_encrypt  in  NUM_REQ  per-requester direction: 1 = forward S-box, 0 = inverse.
- req_word  in  NUM_REQ*WORD_BYTES*8  flattened request words; requester i occupies slice i.
- resp_valid  out  NUM_REQ  one-hot result valid, addressed to the owning requester.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_word  out  WORD_BYTES*8  shared result bus.
- sbox_encrypt  out  1  to S-box encrypt input.
- sbox_byte_in  out  8  to S-box byte_in.
- sbox_byte_out  in  8  from S-box byte_out; combinational in the same cycle.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset_n=0 at a rising edge) applies whatever the state:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, resp_valid=0, resp_word=0, busy=0.
  - sbox_byte_in=0, sbox_encrypt=1.
  - Any in-flight job is dropped; no response is ever issued for it.
- States: IDLE, SUB, DONE.
- IDLE:
  - req_ready is combinational: one-hot on the first requester with req_valid=1, searching from rr_ptr upward with wrap; all zero if none.
  - On a handshake: latch word, direction and owner index; clear byte counter cnt; go to SUB.
  - rr_ptr becomes (owner+1) mod NUM_REQ.
  - req_ready is never asserted outside IDLE.
- SUB (WORD_BYTES cycles):
  - sbox_encrypt = latched direction; sbox_byte_in = latched byte cnt, where byte 0 is bits[7:0].
  - At the clock edge, sbox_byte_out is written into result byte cnt and cnt increments.
  - When cnt reaches WORD_BYTES-1, go to DONE.
  - Outside SUB: sbox_byte_in=0, sbox_encrypt=1.
- DONE:
  - resp_valid[owner]=1 and resp_word = assembled result, both held stable until resp_ready[owner]=1.
  - On that handshake go to IDLE; resp_valid drops the following cycle.
  - resp_ready on non-owner bits is ignored.
- Latency: request handshake in cycle 0 gives resp_valid in cycle WORD_BYTES+1 (5 for defaults).
  - Minimum request-to-request spacing is WORD_BYTES+2 cycles, because IDLE lasts one cycle after the response.
  - Back-to-back grants alternate when several requesters hold valid (round-robin fairness).
- Requester rules:
  - Hold req_word/req_encrypt stable while req_valid=1 and not yet accepted.
  - Dropping req_valid before acceptance is legal; arbitration re-evaluates every IDLE cycle.
- Boundary cases:
  - resp_ready held low: stays in DONE indefinitely; other requesters stall (backpressure).
  - Same requester re-requests while its response is pending: not accepted until IDLE.
  - No requests: remains IDLE, busy=0.
  - 8'h00 input: forward gives 8'h63; inverse gives 8'h52 because inverse-affine(0x00)=0x05, then inverted. Passed through with no special casing.

Decomposition:
- Shared Verilog include (aes_sbox_defs.vh):
  - state encodings IDLE/SUB/DONE (2 bits).
  - SBOX_FWD=1'b1, SBOX_INV=1'b0.
  - byte-lane width constant 8.
- One sub-module, rr_arbiter (NUM_REQ parameter):
  - inputs: request vector, rr_ptr.
  - outputs: one-hot grant and encoded index; purely combinational.
- rr_ptr register, counter, result register and FSM live in sbox_share_sched.
- Testbench instantiates sbox_inv_lut on the sbox_* ports.

Test Plan:
- Reset then idle 10 cycles -> req_ready=0, resp_valid=0, busy=0, sbox_byte_in=0, sbox_encrypt=1 throughout.
- Req0 forward, word 32'hFF530100 -> resp_valid[0] exactly 5 cycles after handshake, resp_word=32'h16ED7C63.
- Req1 inverse, word 32'h16ED7C63 -> resp_word=32'hFF530100 on resp_valid[1]; sbox_encrypt=0 during the 4 SUB cycles.
- Both requesters valid continuously, resp_ready=1 -> grants alternate 0,1,0,1 with 6-cycle spacing; each response matches its own word and direction.
- Backpressure: resp_ready[0]=0 for 20 cycles with req1 valid -> resp_valid[0] and resp_word held stable, req_ready[1] stays 0; accepted in the IDLE cycle after release.
- reset_n pulsed low during SUB cnt=2 -> next cycle IDLE with all outputs at reset values; no resp_valid for the aborted job; rr_ptr=0, so req0 wins a simultaneous request.
